// File: rtl/binary_image_threshold.sv
// binary_image_threshold: RGB-to-gray thresholding pipeline with frame-aligned threshold updates and white-pixel count.
module binary_image_threshold #(
    parameter int IMG_WIDTH_DATA = 24,
    parameter int IMG_WIDTH_LINE = 640,
    parameter int IMG_HEIGHT     = 480,
    parameter int THRESH_DEFAULT = 128
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [IMG_WIDTH_DATA-1:0] data_in,
    input  logic                      data_in_en,
    input  logic [7:0]                thresh_in,
    input  logic                      thresh_wr,
    output logic [IMG_WIDTH_DATA-1:0] data_out,
    output logic                      data_out_en,
    output logic                      frame_done,
    output logic [19:0]               white_cnt
);
    localparam int CW = $clog2(IMG_WIDTH_LINE + 1);
    localparam int RW = $clog2(IMG_HEIGHT + 1);

    logic [CW-1:0] col;
    logic [RW-1:0] row;
    logic [7:0]    thr_act, thr_pend, thr_px, thr1, thr2, gray2;
    logic          pend, first, line_end, last_px, white2;
    logic [15:0]   p_r, p_g, p_b, sum;
    logic          v1, l1, v2, l2;
    logic [19:0]   run, run_inc;

    always_comb begin
        first    = col == '0 && row == '0;
        line_end = col == CW'(IMG_WIDTH_LINE - 1);
        last_px  = line_end && row == RW'(IMG_HEIGHT - 1);
        // The first pixel of a frame already sees a pending threshold
        thr_px   = first && pend ? thr_pend : thr_act;
        sum      = p_r + p_g + p_b;
        white2   = gray2 >= thr2;
        run_inc  = v2 && white2 && run != 20'hfffff ? run + 20'd1 : run;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            col      <= '0;
            row      <= '0;
            thr_act  <= 8'(THRESH_DEFAULT);
            thr_pend <= 8'(THRESH_DEFAULT);
            pend     <= 1'b0;
        end else begin
            if (data_in_en) begin
                col <= line_end ? '0 : col + CW'(1);
                row <= !line_end ? row : row == RW'(IMG_HEIGHT - 1) ? '0 : row + RW'(1);
            end
            if (data_in_en && first && pend)
                thr_act <= thr_pend;
            // A write coinciding with the frame start stays pending for the next frame
            if (thresh_wr) begin
                thr_pend <= thresh_in;
                pend     <= 1'b1;
            end else if (data_in_en && first)
                pend <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_r         <= '0;
            p_g         <= '0;
            p_b         <= '0;
            thr1        <= '0;
            v1          <= 1'b0;
            l1          <= 1'b0;
            gray2       <= '0;
            thr2        <= '0;
            v2          <= 1'b0;
            l2          <= 1'b0;
            data_out    <= '0;
            data_out_en <= 1'b0;
            frame_done  <= 1'b0;
            white_cnt   <= '0;
            run         <= '0;
        end else begin
            p_r         <= 16'(77) * 16'(data_in[23:16]);
            p_g         <= 16'(150) * 16'(data_in[15:8]);
            p_b         <= 16'(29) * 16'(data_in[7:0]);
            thr1        <= thr_px;
            v1          <= data_in_en;
            l1          <= data_in_en && last_px;
            gray2       <= sum[15:8];
            thr2        <= thr1;
            v2          <= v1;
            l2          <= v1 && l1;
            data_out_en <= v2;
            frame_done  <= v2 && l2;
            if (v2)
                data_out <= {IMG_WIDTH_DATA{white2}};
            if (v2 && l2) begin
                white_cnt <= run_inc;
                run       <= '0;
            end else
                run <= run_inc;
        end
    end
endmodule

// File: tb/tb_binary_image_threshold.sv
// tb_binary_image_threshold: table vectors plus threshold/reset sequences on a 4x2 frame, checked through a scoreboard.
module tb_binary_image_threshold;
    logic        clk = 1'b0, rst_n = 1'b1;
    logic [23:0] data_in = '0, data_out;
    logic        data_in_en = 1'b0, thresh_wr = 1'b0, data_out_en, frame_done;
    logic [7:0]  thresh_in = '0;
    logic [19:0] white_cnt;

    typedef struct { logic [23:0] pix; logic w; } vec_t;
    typedef struct { int due; logic [23:0] d; logic fd; logic [19:0] wc; } exp_t;

    vec_t        tbl[8];
    exp_t        q[$];
    int          cyc = 0, total = 0, bad = 0, pos = 0;
    logic [19:0] wc_m = '0;
    logic [23:0] last_out = '0;

    binary_image_threshold #(.IMG_WIDTH_DATA(24), .IMG_WIDTH_LINE(4), .IMG_HEIGHT(2), .THRESH_DEFAULT(128)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .data_in_en(data_in_en),
        .thresh_in(thresh_in), .thresh_wr(thresh_wr), .data_out(data_out),
        .data_out_en(data_out_en), .frame_done(frame_done), .white_cnt(white_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic px(input logic en, input logic [23:0] d, input logic w, input logic tw, input logic [7:0] tv);
        exp_t e;
        @(posedge clk);
        #1;
        data_in_en = en;
        data_in    = d;
        thresh_wr  = tw;
        thresh_in  = tv;
        if (en) begin
            e.due = cyc + 3;
            e.d   = {24{w}};
            e.fd  = pos == 7;
            wc_m  = wc_m + 20'(w);
            e.wc  = wc_m;
            if (e.fd) wc_m = '0;
            pos = (pos + 1) % 8;
            q.push_back(e);
        end
    endtask

    task automatic run_px(input int n, input logic [23:0] d, input logic w);
        for (int i = 0; i < n; i++) px(1'b1, d, w, 1'b0, 8'd0);
    endtask

    always @(negedge clk) begin
        logic exp_en;
        if (rst_n) begin
            exp_en = q.size() > 0 && q[0].due == cyc;
            chk("out_en", 32'(data_out_en), 32'(exp_en));
            if (exp_en) begin
                chk("data_out", 32'(data_out), 32'(q[0].d));
                chk("frame_done", 32'(frame_done), 32'(q[0].fd));
                if (q[0].fd) chk("white_cnt", 32'(white_cnt), 32'(q[0].wc));
                last_out = data_out;
                void'(q.pop_front());
            end else begin
                chk("hold", 32'(data_out), 32'(last_out));
                chk("fd_idle", 32'(frame_done), 32'd0);
            end
        end
    end

    initial begin
        tbl[0] = '{24'h808080, 1'b1};
        tbl[1] = '{24'h7f7f7f, 1'b0};
        tbl[2] = '{24'hff0000, 1'b0};
        tbl[3] = '{24'hffffff, 1'b1};
        tbl[4] = '{24'h000000, 1'b0};
        tbl[5] = '{24'h00ff00, 1'b1};
        tbl[6] = '{24'h0000ff, 1'b0};
        tbl[7] = '{24'h010101, 1'b0};
        #2 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_data", 32'(data_out), 32'd0);
        chk("rst_en", 32'(data_out_en), 32'd0);
        chk("rst_fd", 32'(frame_done), 32'd0);
        chk("rst_wc", 32'(white_cnt), 32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) px(1'b1, tbl[i].pix, tbl[i].w, 1'b0, 8'd0);
        for (int i = 0; i < 16; i++) px(1'(i % 2 == 0), i % 2 == 0 ? 24'h808080 : 24'hffffff, 1'b1, 1'b0, 8'd0);
        run_px(3, 24'hc0c0c0, 1'b1);
        px(1'b1, 24'hc0c0c0, 1'b1, 1'b1, 8'd200);
        run_px(4, 24'hc0c0c0, 1'b1);
        run_px(8, 24'hc0c0c0, 1'b0);
        px(1'b1, 24'h969696, 1'b0, 1'b1, 8'd100);
        run_px(7, 24'h969696, 1'b0);
        run_px(3, 24'h404040, 1'b0);
        px(1'b0, 24'h0, 1'b0, 1'b1, 8'd50);
        run_px(5, 24'h404040, 1'b0);
        px(1'b1, 24'h404040, 1'b1, 1'b1, 8'd250);
        run_px(7, 24'h404040, 1'b1);
        run_px(4, 24'hc0c0c0, 1'b0);
        run_px(4, 24'hffffff, 1'b1);
        run_px(3, 24'hffffff, 1'b1);
        px(1'b0, 24'h0, 1'b0, 1'b1, 8'd10);
        px(1'b0, 24'h0, 1'b0, 1'b0, 8'd0);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_data", 32'(data_out), 32'd0);
        chk("mid_rst_en", 32'(data_out_en), 32'd0);
        chk("mid_rst_fd", 32'(frame_done), 32'd0);
        chk("mid_rst_wc", 32'(white_cnt), 32'd0);
        q.delete();
        pos = 0;
        wc_m = '0;
        last_out = '0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        px(1'b1, 24'h7f7f7f, 1'b0, 1'b0, 8'd0);
        run_px(7, 24'h808080, 1'b1);
        repeat (6) px(1'b0, 24'h0, 1'b0, 1'b0, 8'd0);
        @(posedge clk);
        chk("drain", 32'(q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/binary_image_threshold.md
BINARY_IMAGE_THRESHOLD -- requirements
Module: binary_image_threshold

Interface
REQ-001 The block SHALL have parameter IMG_WIDTH_DATA, default 24, pixel width in bits (R = [23:16], G = [15:8], B = [7:0]).
REQ-002 The block SHALL have parameter IMG_WIDTH_LINE, default 640, pixels per line.
REQ-003 The block SHALL have parameter IMG_HEIGHT, default 480, lines per frame.
REQ-004 The block SHALL have parameter THRESH_DEFAULT, default 128, active threshold after reset.
REQ-005 The block SHALL have port clk, input, 1 bit, pixel clock; the design has one clock.
REQ-006 The block SHALL have port rst_n, input, 1 bit, reset that is asynchronous and active-low.
REQ-007 The block SHALL have port data_in, input, IMG_WIDTH_DATA bits, RGB pixel.
REQ-008 The block SHALL have port data_in_en, input, 1 bit, pixel valid.
REQ-009 The block SHALL have port thresh_in, input, 8 bits, new threshold value.
REQ-010 The block SHALL have port thresh_wr, input, 1 bit, single-cycle write strobe for thresh_in.
REQ-011 The block SHALL have port data_out, output, IMG_WIDTH_DATA bits, binary pixel: 24'hffffff or 24'h000000.
REQ-012 The block SHALL have port data_out_en, output, 1 bit, data_out valid.
REQ-013 The block SHALL have port frame_done, output, 1 bit, one-cycle pulse for the last pixel of a frame.
REQ-014 The block SHALL have port white_cnt, output, 20 bits, count of white pixels in the last completed frame.

Function
REQ-015 Gray SHALL be (77*R + 150*G + 29*B) >> 8, computed with a 16-bit unsigned sum and an 8-bit result; the result SHALL never overflow (maximum 255).
REQ-016 data_out SHALL be 24'hffffff when gray >= the pixel's threshold and 24'h000000 otherwise.
REQ-017 The pipeline SHALL have 3 stages:
- S1 registers the products and the pixel's threshold.
- S2 registers gray.
- S3 registers data_out.
REQ-018 The pipeline SHALL advance every cycle; data_out_en SHALL equal data_in_en delayed by exactly 3 cycles.
REQ-019 data_out SHALL hold its last value when data_out_en is 0.
REQ-020 Column counter col SHALL cover 0..IMG_WIDTH_LINE-1 and increment on each data_in_en.
- At IMG_WIDTH_LINE-1 it SHALL wrap to 0 and increment row.
- row SHALL cover 0..IMG_HEIGHT-1 and wrap to 0 after the last line.
- Cycles with data_in_en = 0 SHALL NOT change either counter.
REQ-021 thresh_wr SHALL load thresh_in into a pending register and set a pending flag; a later thresh_wr before it is applied SHALL overwrite the pending value.
REQ-022 Applying a pending threshold at a frame start:
- When a pixel is accepted at col = 0, row = 0 and the pending flag is set, the pending value SHALL become the active threshold and the flag SHALL clear.
- That pixel SHALL already use the new value.
REQ-023 If thresh_wr coincides with the acceptance of the col = 0, row = 0 pixel, then:
- the previously pending value, if any, SHALL be applied to this frame;
- the new value SHALL become pending for the next frame.
REQ-024 Threshold changes SHALL NEVER take effect mid-frame.
REQ-025 A 20-bit running counter SHALL increment on each valid white output pixel.
REQ-026 frame_done SHALL pulse high in the same cycle data_out_en presents the pixel accepted at row = IMG_HEIGHT-1, col = IMG_WIDTH_LINE-1.
REQ-027 In that frame_done cycle:
- white_cnt SHALL load the running count including that pixel.
- The running counter SHALL reset to 0.
REQ-028 The running counter SHALL saturate at 20'hfffff.

Reset
REQ-029 Asserting rst_n low SHALL immediately set all of the following, including mid-frame:
- data_out = 24'h000000, data_out_en = 0, frame_done = 0, white_cnt = 0.
- Pipeline valid bits cleared.
- col = 0, row = 0, running count = 0.
- Pending flag cleared; active threshold = THRESH_DEFAULT.
REQ-030 After rst_n deassertion, the first accepted pixel SHALL be treated as col = 0, row = 0.

Verification
REQ-031 Reset, then data_in = 24'h808080 with data_in_en for 1 cycle -> data_out_en high exactly 3 cycles later, data_out = 24'hffffff (gray 128 >= 128).
REQ-032 data_in = 24'h7f7f7f -> data_out = 24'h000000; data_in = 24'hff0000 -> gray 76 -> 24'h000000; data_in = 24'hffffff -> gray 255 -> 24'hffffff.
REQ-033 Gated stream: data_in_en toggling 1010... -> data_out_en reproduces the same pattern delayed by 3 cycles; col advances only on enabled cycles.
REQ-034 Full frame with IMG_WIDTH_LINE = 4, IMG_HEIGHT = 2 and 3 white pixels -> one frame_done pulse aligned with the 8th output; white_cnt = 3; next frame counting restarts from 0.
REQ-035 thresh_wr with thresh_in = 200 at mid-frame -> the remaining pixels of 24'hc0c0c0 stay white; from the next frame's first pixel they output black. thresh_wr coincident with the first pixel -> the new value applies only from the following frame.
REQ-036 rst_n pulsed low mid-frame after a pending write -> all outputs 0 immediately; the next frame uses threshold 128; the first pixel after reset is col = 0, row = 0.
